// File: rtl/sr_axi_burst_adapter.sv
// sr_axi_burst_adapter: core single-request memory port to AXI4 manager.
// Each core word is carried as one INCR burst; one transaction in flight.
package sr_axi_pkg;
    localparam int AXI_ID_MAX   = 8;
    localparam int AXI_ADDR_MAX = 32;
    localparam int AXI_DATA_MAX = 64;

    typedef struct packed {
        logic [AXI_ID_MAX-1:0]     awid;
        logic [AXI_ADDR_MAX-1:0]   awaddr;
        logic [7:0]                awlen;
        logic [2:0]                awsize;
        logic [1:0]                awburst;
        logic                      awvalid;
        logic [AXI_DATA_MAX-1:0]   wdata;
        logic [AXI_DATA_MAX/8-1:0] wstrb;
        logic                      wlast;
        logic                      wvalid;
        logic                      bready;
        logic [AXI_ID_MAX-1:0]     arid;
        logic [AXI_ADDR_MAX-1:0]   araddr;
        logic [7:0]                arlen;
        logic [2:0]                arsize;
        logic [1:0]                arburst;
        logic                      arvalid;
        logic                      rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                      awready;
        logic                      wready;
        logic [AXI_ID_MAX-1:0]     bid;
        logic [1:0]                bresp;
        logic                      bvalid;
        logic                      arready;
        logic [AXI_ID_MAX-1:0]     rid;
        logic [AXI_DATA_MAX-1:0]   rdata;
        logic [1:0]                rresp;
        logic                      rlast;
        logic                      rvalid;
    } axi_miso_t;
endpackage

module sr_axi_burst_adapter
    import sr_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int ID_WIDTH       = 4,
    parameter int ID_SHIFT       = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_wr_i,
    input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] mem_wdata_i,
    input  logic                      mem_req_valid_i,
    output logic                      mem_req_ready_o,
    output logic                      mem_resp_valid_o,
    input  logic                      mem_resp_ready_i,
    output logic [MEM_DATA_WIDTH-1:0] mem_rdata_o,
    output logic                      mem_resp_err_o,
    input  axi_miso_t                 in_miso_i,
    output axi_mosi_t                 in_mosi_o
);
    localparam int BEATS = MEM_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int SIZE  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int BW    = $clog2(BEATS + 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [BW-1:0] FULL = BW'(BEATS);

    typedef enum logic [2:0] {
        IDLE, WRITE, WR_RESP, READ_ADDR, RD_DATA, RESP
    } state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [MEM_DATA_WIDTH-1:0] wdata_q;
    logic [MEM_DATA_WIDTH-1:0] rdata_q;
    logic [BW-1:0]             beat_q;
    logic                      err_q;
    logic                      aw_done_q;
    logic                      w_done_q;

    logic [ID_WIDTH-1:0]       axid;
    logic [AXI_DATA_WIDTH-1:0] wbeat;
    logic                      awvalid, wvalid, arvalid;
    logic                      bready, rready;
    logic                      aw_fire, w_fire, w_last;
    logic                      b_fire, ar_fire, r_fire;
    logic                      unused_ok;

    assign axid = ID_WIDTH'((addr_q >> ID_SHIFT) + ADDR_WIDTH'(1));

    assign awvalid = (state == WRITE) && !aw_done_q;
    assign wvalid  = (state == WRITE) && !w_done_q;
    assign bready  = (state == WR_RESP);
    assign arvalid = (state == READ_ADDR);
    assign rready  = (state == RD_DATA);

    assign aw_fire = awvalid && in_miso_i.awready;
    assign w_fire  = wvalid && in_miso_i.wready;
    assign w_last  = (beat_q == LAST);
    assign b_fire  = bready && in_miso_i.bvalid;
    assign ar_fire = arvalid && in_miso_i.arready;
    assign r_fire  = rready && in_miso_i.rvalid;

    assign mem_req_ready_o  = (state == IDLE);
    assign mem_resp_valid_o = (state == RESP);
    assign mem_resp_err_o   = (state == RESP) && err_q;
    assign mem_rdata_o      = rdata_q;

    assign unused_ok = ^{in_miso_i.bid, in_miso_i.rid, in_miso_i.rdata};

    // Select the current write slice, least significant first.
    always_comb begin
        wbeat = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) begin
                wbeat = wdata_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Drive the AXI manager bundle from registered state.
    always_comb begin
        in_mosi_o         = '0;
        in_mosi_o.awid    = AXI_ID_MAX'(axid);
        in_mosi_o.awaddr  = AXI_ADDR_MAX'(addr_q);
        in_mosi_o.awlen   = 8'(BEATS - 1);
        in_mosi_o.awsize  = 3'(SIZE);
        in_mosi_o.awburst = 2'b01;
        in_mosi_o.awvalid = awvalid;
        in_mosi_o.wdata   = AXI_DATA_MAX'(wbeat);
        in_mosi_o.wstrb   = (AXI_DATA_MAX/8)'({(AXI_DATA_WIDTH/8){1'b1}});
        in_mosi_o.wlast   = w_last;
        in_mosi_o.wvalid  = wvalid;
        in_mosi_o.bready  = bready;
        in_mosi_o.arid    = AXI_ID_MAX'(axid);
        in_mosi_o.araddr  = AXI_ADDR_MAX'(addr_q);
        in_mosi_o.arlen   = 8'(BEATS - 1);
        in_mosi_o.arsize  = 3'(SIZE);
        in_mosi_o.arburst = 2'b01;
        in_mosi_o.arvalid = arvalid;
        in_mosi_o.rready  = rready;
    end

    // Transaction FSM: accept, run the burst, collect status, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_valid_i) begin
                        addr_q    <= mem_addr_i;
                        wdata_q   <= mem_wdata_i;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state     <= mem_wr_i ? WRITE : READ_ADDR;
                    end
                end
                WRITE: begin
                    if (aw_fire) aw_done_q <= 1'b1;
                    if (w_fire) begin
                        if (w_last) w_done_q <= 1'b1;
                        else beat_q <= beat_q + BW'(1);
                    end
                    if ((aw_done_q || aw_fire) &&
                        (w_done_q || (w_fire && w_last))) begin
                        state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_fire) begin
                        err_q <= err_q || (in_miso_i.bresp != 2'b00);
                        state <= RESP;
                    end
                end
                READ_ADDR: begin
                    if (ar_fire) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_fire) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_q == BW'(i)) begin
                                rdata_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                                    <= in_miso_i.rdata[AXI_DATA_WIDTH-1:0];
                            end
                        end
                        if (beat_q != FULL) beat_q <= beat_q + BW'(1);
                        err_q <= err_q || (in_miso_i.rresp != 2'b00) ||
                                 (in_miso_i.rlast && (beat_q != LAST));
                        if (in_miso_i.rlast) state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_axi_burst_adapter.sv
// tb_sr_axi_burst_adapter: randomized bench with an AXI subordinate model.
// Two instances: default widths and a 64/32 variant, selected by sel.
`timescale 1ns/1ps
module tb_sr_axi_burst_adapter;
    import sr_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_req_valid;
    logic        mem_resp_ready;
    logic        req_ready0, req_ready1, resp_valid0, resp_valid1;
    logic        err0, err1;
    logic [31:0] rdata0;
    logic [63:0] rdata1;
    axi_mosi_t   mosi0, mosi1, mosi;
    axi_miso_t   miso_drv, miso0, miso1;
    logic        v0, v1, rr0, rr1;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    assign miso0      = sel ? '0 : miso_drv;
    assign miso1      = sel ? miso_drv : '0;
    assign v0         = mem_req_valid & ~sel;
    assign v1         = mem_req_valid & sel;
    assign rr0        = mem_resp_ready & ~sel;
    assign rr1        = mem_resp_ready & sel;
    assign mosi       = sel ? mosi1 : mosi0;
    assign req_ready  = sel ? req_ready1 : req_ready0;
    assign resp_valid = sel ? resp_valid1 : resp_valid0;
    assign resp_err   = sel ? err1 : err0;
    assign resp_rdata = sel ? rdata1 : {32'b0, rdata0};

    sr_axi_burst_adapter dut0 (
        .clk(clk), .rst(rst),
        .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata[31:0]),
        .mem_req_valid_i(v0), .mem_req_ready_o(req_ready0),
        .mem_resp_valid_o(resp_valid0), .mem_resp_ready_i(rr0),
        .mem_rdata_o(rdata0), .mem_resp_err_o(err0),
        .in_miso_i(miso0), .in_mosi_o(mosi0)
    );

    sr_axi_burst_adapter #(
        .MEM_DATA_WIDTH(64), .AXI_DATA_WIDTH(32)
    ) dut1 (
        .clk(clk), .rst(rst),
        .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_req_valid_i(v1), .mem_req_ready_o(req_ready1),
        .mem_resp_valid_o(resp_valid1), .mem_resp_ready_i(rr1),
        .mem_rdata_o(rdata1), .mem_resp_err_o(err1),
        .in_miso_i(miso1), .in_mosi_o(mosi1)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [63:0] prev [2];
    logic [63:0] rvals [8];
    logic [1:0]  rresps [8];

    int t_req, t_aw, t_w0, t_wl, t_b, t_ar, t_r0, t_rl, t_resp;
    int resp_cycles;
    bit timeout, stable, wstrb_bad, wlast_bad;
    logic [7:0]  o_id, o_len;
    logic [31:0] o_addr;
    logic [2:0]  o_size;
    logic [1:0]  o_burst;
    logic [63:0] o_wbeats [$];
    logic [63:0] o_rdata;
    logic        o_err;

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    function automatic int nbeats();
        return sel ? 2 : 4;
    endfunction

    function automatic int adw();
        return sel ? 32 : 8;
    endfunction

    function automatic logic [63:0] dmask();
        return (64'd1 << adw()) - 64'd1;
    endfunction

    function automatic logic [7:0] exp_id(input logic [15:0] a);
        return 8'(((a >> 12) + 16'd1) & 16'hF);
    endfunction

    function automatic logic [63:0] exp_wbeat(input logic [63:0] w, input int i);
        return (w >> (i * adw())) & dmask();
    endfunction

    function automatic logic [63:0] model_read(input int last);
        logic [63:0] r;
        r = prev[sel];
        for (int i = 0; i < nbeats() && i <= last; i++) begin
            r = (r & ~(dmask() << (i * adw()))) |
                ((rvals[i] & dmask()) << (i * adw()));
        end
        if (!sel) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic model_rerr(input int last);
        logic e;
        e = (last != nbeats() - 1);
        for (int i = 0; i <= last; i++) e = e | (rresps[i] != 2'b00);
        return e;
    endfunction

    // Acts as core and AXI subordinate for one transaction, recording events.
    task automatic run_txn(input bit wr, input logic [15:0] addr,
                           input logic [63:0] wdata, input int awdly,
                           input int pct, input int rlast_idx,
                           input logic [1:0] bresp, input int resp_hold);
        int aw_first, waited, ridx;
        bit aw_ok, w_ok, b_ok, ar_seen, ar_ok, r_ok, r_hold, resp_ok;
        t_aw = -1; t_w0 = -1; t_wl = -1; t_b = -1;
        t_ar = -1; t_r0 = -1; t_rl = -1; t_resp = -1;
        resp_cycles = 0; timeout = 0; stable = 1;
        wstrb_bad = 0; wlast_bad = 0; o_wbeats.delete();
        o_id = '0; o_len = '0; o_addr = '0; o_size = '0; o_burst = '0;
        o_rdata = '0; o_err = 1'b0;
        aw_first = -1; ridx = 0;
        aw_ok = 0; w_ok = 0; b_ok = 0; ar_seen = 0; ar_ok = 0;
        r_ok = 0; r_hold = 0; resp_ok = 0;
        step();
        miso_drv = '0;
        mem_resp_ready = 1'b0;
        mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
        mem_req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!req_ready) begin
            timeout = 1;
            mem_req_valid = 1'b0;
            return;
        end
        t_req = n;
        step();
        mem_req_valid = 1'b0;
        mem_wr = 1'($urandom);
        mem_addr = 16'($urandom);
        mem_wdata = {$urandom, $urandom};
        for (int k = 0; k < 200 && !resp_ok; k++) begin
            miso_drv = '0;
            if (mosi.awvalid) begin
                if (aw_first < 0) begin
                    aw_first = n;
                    o_id = mosi.awid; o_addr = mosi.awaddr;
                    o_len = mosi.awlen; o_size = mosi.awsize;
                    o_burst = mosi.awburst;
                end
                if (n - aw_first >= awdly) begin
                    miso_drv.awready = 1'b1;
                    t_aw = n; aw_ok = 1;
                end
            end
            if (mosi.wvalid && ($urandom_range(99) < pct)) begin
                miso_drv.wready = 1'b1;
                if (o_wbeats.size() == 0) t_w0 = n;
                o_wbeats.push_back(mosi.wdata);
                if (mosi.wstrb != 8'((1 << (adw() / 8)) - 1)) wstrb_bad = 1;
                if (mosi.wlast != (o_wbeats.size() == nbeats())) wlast_bad = 1;
                if (mosi.wlast) begin
                    t_wl = n; w_ok = 1;
                end
            end
            if (aw_ok && w_ok && !b_ok && n > t_aw && n > t_wl) begin
                miso_drv.bvalid = 1'b1;
                miso_drv.bresp = bresp;
                if (mosi.bready) begin
                    t_b = n; b_ok = 1;
                end
            end
            if (mosi.arvalid) begin
                if (!ar_seen) begin
                    ar_seen = 1;
                    o_id = mosi.arid; o_addr = mosi.araddr;
                    o_len = mosi.arlen; o_size = mosi.arsize;
                    o_burst = mosi.arburst;
                end
                if ($urandom_range(99) < pct) begin
                    miso_drv.arready = 1'b1;
                    t_ar = n; ar_ok = 1;
                end
            end
            if (ar_ok && !r_ok && n > t_ar &&
                (r_hold || $urandom_range(99) < pct)) begin
                miso_drv.rvalid = 1'b1;
                miso_drv.rdata = rvals[ridx];
                miso_drv.rresp = rresps[ridx];
                miso_drv.rlast = (ridx == rlast_idx);
                if (mosi.rready) begin
                    if (ridx == 0) t_r0 = n;
                    if (ridx == rlast_idx) begin
                        t_rl = n; r_ok = 1;
                    end
                    ridx++;
                    r_hold = 0;
                end else begin
                    r_hold = 1;
                end
            end
            if (resp_valid) begin
                if (resp_cycles == 0) begin
                    t_resp = n; o_rdata = resp_rdata; o_err = resp_err;
                end else if (resp_rdata !== o_rdata || resp_err !== o_err) begin
                    stable = 0;
                end
                resp_cycles++;
                mem_resp_ready = (resp_cycles > resp_hold);
                if (mem_resp_ready) resp_ok = 1;
            end else begin
                mem_resp_ready = 1'b0;
            end
            step();
        end
        miso_drv = '0;
        mem_resp_ready = 1'b0;
        if (!resp_ok) timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checks++;
            if ({mosi.awvalid, mosi.wvalid, mosi.bready,
                 mosi.arvalid, mosi.rready} !== 5'b0) begin
                errors++;
                $display("FAIL reset_axi dut%0d got %b exp 00000", s,
                    {mosi.awvalid, mosi.wvalid, mosi.bready,
                     mosi.arvalid, mosi.rready});
            end
            checks++;
            if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
                errors++;
                $display("FAIL reset_mem dut%0d got %b exp 100", s,
                    {req_ready, resp_valid, resp_err});
            end
            checks++;
            if (resp_rdata !== 64'd0) begin
                errors++;
                $display("FAIL reset_rdata dut%0d got %0h exp 0", s, resp_rdata);
            end
        end
        sel = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_basic();
        sel = 1'b0;
        run_txn(1, 16'h1234, 64'hA1B2C3D4, 0, 100, 3, 2'b00, 0);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL wr_timeout got timeout exp response");
        end
        checks++;
        if ({o_id, o_len, o_size, o_burst} !== {8'd2, 8'd3, 3'd0, 2'b01}) begin
            errors++;
            $display("FAIL wr_aw_fields got id %0d len %0d size %0d burst %0d exp 2 3 0 1",
                o_id, o_len, o_size, o_burst);
        end
        checks++;
        if (o_addr !== 32'h1234) begin
            errors++;
            $display("FAIL wr_awaddr got %0h exp 1234", o_addr);
        end
        checks++;
        if (o_wbeats.size() != 4) begin
            errors++;
            $display("FAIL wr_nbeats got %0d exp 4", o_wbeats.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (o_wbeats[i] !== exp_wbeat(64'hA1B2C3D4, i)) begin
                    errors++;
                    $display("FAIL wr_wdata beat %0d got %0h exp %0h", i,
                        o_wbeats[i], exp_wbeat(64'hA1B2C3D4, i));
                end
            end
        end
        checks++;
        if (wlast_bad || wstrb_bad) begin
            errors++;
            $display("FAIL wr_wlast_wstrb got last_bad %0d strb_bad %0d exp 0 0",
                wlast_bad, wstrb_bad);
        end
        checks++;
        if ({t_aw, t_w0, t_wl, t_b, t_resp} !==
            {t_req + 1, t_req + 1, t_req + 4, t_req + 5, t_req + 6}) begin
            errors++;
            $display("FAIL wr_timing got aw %0d w0 %0d wl %0d b %0d resp %0d exp 1 1 4 5 6",
                t_aw - t_req, t_w0 - t_req, t_wl - t_req, t_b - t_req, t_resp - t_req);
        end
        checks++;
        if (o_err !== 1'b0 || o_rdata !== prev[0]) begin
            errors++;
            $display("FAIL wr_resp got err %0d rdata %0h exp 0 %0h", o_err, o_rdata, prev[0]);
        end
    endtask

    task automatic test_read_basic();
        logic [63:0] exp;
        sel = 1'b0;
        rvals[0] = 64'h11; rvals[1] = 64'h22; rvals[2] = 64'h33; rvals[3] = 64'h44;
        for (int i = 0; i < 8; i++) rresps[i] = 2'b00;
        exp = model_read(3);
        run_txn(0, 16'h3000, 64'h0, 0, 100, 3, 2'b00, 0);
        checks++;
        if (timeout || {o_id, o_len, o_addr} !== {8'd4, 8'd3, 32'h3000}) begin
            errors++;
            $display("FAIL rd_ar_fields got to %0d id %0d len %0d addr %0h exp 0 4 3 3000",
                timeout, o_id, o_len, o_addr);
        end
        checks++;
        if ({t_ar, t_r0, t_rl, t_resp} !==
            {t_req + 1, t_req + 2, t_req + 5, t_req + 6}) begin
            errors++;
            $display("FAIL rd_timing got ar %0d r0 %0d rl %0d resp %0d exp 1 2 5 6",
                t_ar - t_req, t_r0 - t_req, t_rl - t_req, t_resp - t_req);
        end
        checks++;
        if (o_rdata !== 64'h44332211 || exp !== 64'h44332211 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got %0h err %0d exp 44332211 0", o_rdata, o_err);
        end
        prev[0] = exp;
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        run_txn(1, 16'h0abc, 64'h5566_7788, 5, 100, 3, 2'b00, 3);
        checks++;
        if (timeout || !(t_wl < t_aw) || t_b !== t_aw + 1) begin
            errors++;
            $display("FAIL bp_order got to %0d wl %0d aw %0d b %0d exp wl<aw b=aw+1",
                timeout, t_wl - t_req, t_aw - t_req, t_b - t_req);
        end
        checks++;
        if (resp_cycles != 4 || !stable || o_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp got cycles %0d stable %0d err %0d exp 4 1 0",
                resp_cycles, stable, o_err);
        end
        checks++;
        if (o_wbeats.size() != 4 || o_wbeats[3] !== 64'h55 || o_wbeats[0] !== 64'h88) begin
            errors++;
            $display("FAIL bp_wdata got n %0d exp 4 beats 88..55", o_wbeats.size());
        end
    endtask

    task automatic test_errors();
        logic [63:0] exp;
        sel = 1'b0;
        run_txn(1, 16'h1000, 64'hdead_beef, 0, 100, 3, 2'b10, 0);
        checks++;
        if (timeout || o_err !== 1'b1) begin
            errors++;
            $display("FAIL err_bresp got to %0d err %0d exp 0 1", timeout, o_err);
        end
        for (int i = 0; i < 8; i++) begin
            rvals[i] = {$urandom, $urandom};
            rresps[i] = 2'b00;
        end
        exp = model_read(1);
        run_txn(0, 16'h2000, 64'h0, 0, 100, 1, 2'b00, 0);
        checks++;
        if (timeout || o_err !== 1'b1 || o_rdata !== exp) begin
            errors++;
            $display("FAIL err_short_rlast got to %0d err %0d data %0h exp 0 1 %0h",
                timeout, o_err, o_rdata, exp);
        end
        prev[0] = exp;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_idle got req_ready %0d exp 1", req_ready);
        end
        exp = model_read(5);
        run_txn(0, 16'h2004, 64'h0, 0, 100, 5, 2'b00, 0);
        checks++;
        if (timeout || o_err !== 1'b1 || o_rdata !== exp) begin
            errors++;
            $display("FAIL err_long_burst got to %0d err %0d data %0h exp 0 1 %0h",
                timeout, o_err, o_rdata, exp);
        end
        prev[0] = exp;
        rresps[2] = 2'b11;
        exp = model_read(3);
        run_txn(0, 16'h2008, 64'h0, 0, 100, 3, 2'b00, 0);
        checks++;
        if (timeout || o_err !== 1'b1 || o_rdata !== exp) begin
            errors++;
            $display("FAIL err_rresp got to %0d err %0d data %0h exp 0 1 %0h",
                timeout, o_err, o_rdata, exp);
        end
        prev[0] = exp;
        rresps[2] = 2'b00;
        exp = model_read(3);
        run_txn(0, 16'h200c, 64'h0, 0, 100, 3, 2'b00, 0);
        checks++;
        if (timeout || o_err !== 1'b0 || o_rdata !== exp) begin
            errors++;
            $display("FAIL err_clean_read got to %0d err %0d data %0h exp 0 0 %0h",
                timeout, o_err, o_rdata, exp);
        end
        prev[0] = exp;
    endtask

    task automatic test_param_variant();
        logic [63:0] exp, w;
        sel = 1'b1;
        w = 64'h0123_4567_89ab_cdef;
        run_txn(1, 16'h5010, w, 0, 100, 1, 2'b00, 0);
        checks++;
        if (timeout || {o_id, o_len, o_size} !== {8'd6, 8'd1, 3'd2}) begin
            errors++;
            $display("FAIL pv_aw got to %0d id %0d len %0d size %0d exp 0 6 1 2",
                timeout, o_id, o_len, o_size);
        end
        checks++;
        if (o_wbeats.size() != 2 || o_wbeats[0] !== 64'h89ab_cdef ||
            o_wbeats[1] !== 64'h0123_4567 || wlast_bad || wstrb_bad) begin
            errors++;
            $display("FAIL pv_wdata got n %0d strb_bad %0d last_bad %0d exp 2 0 0",
                o_wbeats.size(), wstrb_bad, wlast_bad);
        end
        checks++;
        if (t_resp !== t_req + 4 || t_b !== t_req + 3) begin
            errors++;
            $display("FAIL pv_wr_timing got b %0d resp %0d exp 3 4",
                t_b - t_req, t_resp - t_req);
        end
        for (int i = 0; i < 8; i++) begin
            rvals[i] = {$urandom, $urandom};
            rresps[i] = 2'b00;
        end
        exp = model_read(1);
        run_txn(0, 16'hf000, 64'h0, 0, 100, 1, 2'b00, 0);
        checks++;
        if (timeout || o_rdata !== {rvals[1][31:0], rvals[0][31:0]} ||
            o_rdata !== exp || o_err !== 1'b0 || o_id !== 8'd0) begin
            errors++;
            $display("FAIL pv_read got to %0d data %0h err %0d id %0d exp 0 %0h 0 0",
                timeout, o_rdata, o_err, o_id, exp);
        end
        checks++;
        if (t_resp !== t_req + 4) begin
            errors++;
            $display("FAIL pv_rd_timing got resp %0d exp 4", t_resp - t_req);
        end
        prev[1] = exp;
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        sel = 1'b0;
        step();
        miso_drv = '0;
        mem_wr = 1'b0; mem_addr = 16'h2000; mem_req_valid = 1'b1;
        step();
        mem_req_valid = 1'b0;
        miso_drv.arready = mosi.arvalid;
        step();
        miso_drv = '0;
        checks++;
        if (mosi.rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_entry got rready %0d exp 1", mosi.rready);
        end
        miso_drv.rvalid = 1'b1; miso_drv.rdata = 64'h5a;
        step();
        miso_drv.rvalid = 1'b1; miso_drv.rdata = 64'h6b;
        rst = 1'b1;
        step();
        miso_drv.bvalid = 1'b1;
        checks++;
        if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid,
             mosi.rready, req_ready, resp_valid} !== 7'b0000010) begin
            errors++;
            $display("FAIL mid_reset got %b exp 0000010",
                {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid,
                 mosi.rready, req_ready, resp_valid});
        end
        checks++;
        if (resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset_rdata got %0h exp 0", resp_rdata);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({mosi.bready, mosi.rready, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_stray got %b exp 001",
                {mosi.bready, mosi.rready, req_ready});
        end
        miso_drv = '0;
        prev[0] = 64'd0;
        prev[1] = 64'd0;
        for (int i = 0; i < 8; i++) rresps[i] = 2'b00;
        exp = model_read(3);
        run_txn(0, 16'h7777, 64'h0, 0, 100, 3, 2'b00, 0);
        checks++;
        if (timeout || o_rdata !== exp || o_err !== 1'b0 || o_id !== 8'd8) begin
            errors++;
            $display("FAIL mid_recover got to %0d data %0h err %0d id %0d exp 0 %0h 0 8",
                timeout, o_rdata, o_err, o_id, exp);
        end
        prev[0] = exp;
    endtask

    task automatic test_random();
        logic [63:0] exp, w;
        logic [15:0] a;
        logic [1:0]  br;
        bit          wr;
        int          last, pct, bad;
        for (int t = 0; t < 24; t++) begin
            step();
            sel = 1'($urandom);
            wr = 1'($urandom);
            a = 16'($urandom);
            w = {$urandom, $urandom};
            if (!sel) w = w & 64'hFFFF_FFFF;
            pct = $urandom_range(100, 40);
            br = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            last = ($urandom_range(4) == 0) ? $urandom_range(5) : nbeats() - 1;
            for (int i = 0; i < 8; i++) begin
                rvals[i] = {$urandom, $urandom};
                rresps[i] = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
            end
            exp = wr ? prev[sel] : model_read(last);
            run_txn(wr, a, w, $urandom_range(3), pct, last, br,
                    $urandom_range(2));
            checks++;
            if (timeout || o_id !== exp_id(a) || o_len !== 8'(nbeats() - 1) ||
                o_addr !== 32'(a) || o_size !== (sel ? 3'd2 : 3'd0)) begin
                errors++;
                $display("FAIL rnd_addr t%0d got to %0d id %0d len %0d addr %0h exp 0 %0d %0d %0h",
                    t, timeout, o_id, o_len, o_addr, exp_id(a), nbeats() - 1, a);
            end
            checks++;
            if (o_rdata !== exp || !stable ||
                o_err !== (wr ? (br != 2'b00) : model_rerr(last))) begin
                errors++;
                $display("FAIL rnd_resp t%0d wr %0d got data %0h err %0d exp %0h %0d",
                    t, wr, o_rdata, o_err, exp,
                    wr ? (br != 2'b00) : model_rerr(last));
            end
            if (wr) begin
                bad = (o_wbeats.size() != nbeats()) || wlast_bad || wstrb_bad;
                for (int i = 0; i < o_wbeats.size() && i < nbeats(); i++) begin
                    if (o_wbeats[i] !== exp_wbeat(w, i)) bad = 1;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rnd_wdata t%0d got n %0d last_bad %0d strb_bad %0d exp %0d 0 0",
                        t, o_wbeats.size(), wlast_bad, wstrb_bad, nbeats());
                end
            end else begin
                prev[sel] = exp;
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        mem_wr = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_req_valid = 1'b0;
        mem_resp_ready = 1'b0;
        miso_drv = '0;
        prev[0] = 64'd0;
        prev[1] = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rvals[i] = '0;
            rresps[i] = 2'b00;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_backpressure();
        test_errors();
        test_param_variant();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
